// File: rtl/bcd_counter2.sv
// Two-digit BCD up/down counter fed by raw pushbutton levels.
// Buttons are synchronized and edge-detected, so each press gives a single step.
module bcd_counter2 #(
  parameter bit         WRAP      = 1'b1,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       clear,
  output logic [3:0] ONES,
  output logic [3:0] TENS,
  output logic       rollover
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] DMAX = DW'(9);

  if (RESET_VAL[7:4] > 4'd9 || RESET_VAL[3:0] > 4'd9) begin : g_bad_reset_val
    $error("bcd_counter2: RESET_VAL nibbles must be BCD digits 0..9");
  end

  logic inc_s1, inc_s2, inc_prev;
  logic dec_s1, dec_s2, dec_prev;
  logic up, down;

  logic [DW-1:0] ones_nxt, tens_nxt;
  logic          roll_nxt;

  // Two-flop synchronizer plus one delay flop per button; all preset to 1
  // so a button held across reset release never looks like a new press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inc_s1   <= 1'b1;
      inc_s2   <= 1'b1;
      inc_prev <= 1'b1;
      dec_s1   <= 1'b1;
      dec_s2   <= 1'b1;
      dec_prev <= 1'b1;
      TENS     <= RESET_VAL[7:4];
      ONES     <= RESET_VAL[3:0];
      rollover <= 1'b0;
    end else begin
      inc_s1   <= inc;
      inc_s2   <= inc_s1;
      inc_prev <= inc_s2;
      dec_s1   <= dec;
      dec_s2   <= dec_s1;
      dec_prev <= dec_s2;
      TENS     <= tens_nxt;
      ONES     <= ones_nxt;
      rollover <= roll_nxt;
    end
  end

  assign up   = inc_s2 & ~inc_prev;
  assign down = dec_s2 & ~dec_prev;

  // Next count: clear wins, simultaneous up/down cancel, ends wrap or saturate.
  always_comb begin
    ones_nxt = ONES;
    tens_nxt = TENS;
    roll_nxt = 1'b0;
    if (clear) begin
      ones_nxt = '0;
      tens_nxt = '0;
    end else if (up && !down) begin
      if (ONES != DMAX) begin
        ones_nxt = ONES + DW'(1);
      end else if (TENS != DMAX) begin
        ones_nxt = '0;
        tens_nxt = TENS + DW'(1);
      end else if (WRAP) begin
        ones_nxt = '0;
        tens_nxt = '0;
        roll_nxt = 1'b1;
      end
    end else if (down && !up) begin
      if (ONES != '0) begin
        ones_nxt = ONES - DW'(1);
      end else if (TENS != '0) begin
        ones_nxt = DMAX;
        tens_nxt = TENS - DW'(1);
      end else if (WRAP) begin
        ones_nxt = DMAX;
        tens_nxt = DMAX;
        roll_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter2.sv
// Directed bench for bcd_counter2: wrapping, saturating and non-zero-reset
// instances share one set of button stimulus.
module tb_bcd_counter2;

  logic clk = 1'b0;
  logic reset, inc, dec, clear;
  logic [3:0] a_ones, a_tens, s_ones, s_tens, r_ones, r_tens;
  logic a_roll, s_roll, r_roll;

  always #5 clk = ~clk;

  bcd_counter2 #(.WRAP(1'b1), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
    .ONES(a_ones), .TENS(a_tens), .rollover(a_roll));
  bcd_counter2 #(.WRAP(1'b0), .RESET_VAL(8'h00)) dut_s (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
    .ONES(s_ones), .TENS(s_tens), .rollover(s_roll));
  bcd_counter2 #(.WRAP(1'b1), .RESET_VAL(8'h25)) dut_r (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear),
    .ONES(r_ones), .TENS(r_tens), .rollover(r_roll));

  typedef struct packed {
    logic       pi;
    logic       pd;
    logic       pc;
    logic [7:0] pre;
    logic [7:0] ea;
    logic       er;
    logic [7:0] es;
  } row_t;

  localparam int NROWS = 23;
  row_t rows [NROWS];

  int n_cmp = 0;
  int n_bad = 0;
  int row_idx = -1;
  int a_roll_cnt = 0;
  int s_roll_cnt = 0;
  logic [7:0] cur_a, cur_s;

  always @(posedge clk) begin
    if (reset && a_roll) a_roll_cnt++;
    if (reset && s_roll) s_roll_cnt++;
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_add(input logic [7:0] x, input int n);
    return to_bcd(int'(x[7:4]) * 10 + int'(x[3:0]) + n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (row %0d): actual %h required %h", nm, row_idx, act, exp);
    end
  endtask

  // Optional burst of quick presses, then one checked press with E+2 timing.
  task automatic apply_row(input row_t r);
    for (int k = 0; k < int'(r.pre); k++) begin
      inc = 1'b1; tick(); tick();
      inc = 1'b0; tick(); tick();
    end
    cur_a = bcd_add(cur_a, int'(r.pre));
    cur_s = bcd_add(cur_s, int'(r.pre));
    inc = r.pi;
    dec = r.pd;
    tick();
    tick();
    chk("a_before_e2", {a_tens, a_ones}, cur_a);
    chk("s_before_e2", {s_tens, s_ones}, cur_s);
    clear = r.pc;
    tick();
    clear = 1'b0;
    chk("a_at_e2", {a_tens, a_ones}, r.ea);
    chk("a_roll_e2", 8'(a_roll), 8'(r.er));
    chk("s_at_e2", {s_tens, s_ones}, r.es);
    chk("s_roll_e2", 8'(s_roll), 8'h00);
    tick();
    chk("a_roll_e3", 8'(a_roll), 8'h00);
    inc = 1'b0;
    dec = 1'b0;
    repeat (4) tick();
    cur_a = r.ea;
    cur_s = r.es;
  endtask

  initial begin
    for (int i = 0; i < 12; i++)
      rows[i] = '{1'b1, 1'b0, 1'b0, 8'd0, to_bcd(i + 1), 1'b0, to_bcd(i + 1)};
    rows[12] = '{1'b1, 1'b1, 1'b0, 8'd23, 8'h35, 1'b0, 8'h35};
    rows[13] = '{1'b1, 1'b0, 1'b1, 8'd0,  8'h00, 1'b0, 8'h00};
    rows[14] = '{1'b1, 1'b0, 1'b0, 8'd99, 8'h00, 1'b1, 8'h99};
    rows[15] = '{1'b0, 1'b1, 1'b0, 8'd0,  8'h99, 1'b1, 8'h98};
    rows[16] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 8'h99};
    rows[17] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'h01, 1'b0, 8'h99};
    rows[18] = '{1'b0, 1'b0, 1'b1, 8'd0,  8'h00, 1'b0, 8'h00};
    rows[19] = '{1'b0, 1'b1, 1'b0, 8'd0,  8'h99, 1'b1, 8'h00};
    rows[20] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 8'h01};
    rows[21] = '{1'b0, 1'b0, 1'b1, 8'd0,  8'h00, 1'b0, 8'h00};
    rows[22] = '{1'b1, 1'b0, 1'b0, 8'd46, 8'h47, 1'b0, 8'h47};

    reset = 1'b0; inc = 1'b0; dec = 1'b0; clear = 1'b0;

    // Reset held while inc toggles, then release with inc low.
    for (int i = 0; i < 3; i++) begin
      inc = ~inc;
      tick();
    end
    chk("rst_a", {a_tens, a_ones}, 8'h00);
    chk("rst_r", {r_tens, r_ones}, 8'h25);
    chk("rst_roll", 8'({a_roll, s_roll, r_roll}), 8'h00);
    reset = 1'b1;
    inc = 1'b0;
    repeat (4) tick();
    chk("rel_a", {a_tens, a_ones}, 8'h00);
    chk("rel_s", {s_tens, s_ones}, 8'h00);
    chk("rel_r", {r_tens, r_ones}, 8'h25);

    // Long holds give exactly one step each.
    inc = 1'b1;
    repeat (20) tick();
    chk("hold_inc_mid", {a_tens, a_ones}, 8'h01);
    inc = 1'b0;
    repeat (4) tick();
    chk("hold_inc_a", {a_tens, a_ones}, 8'h01);
    chk("hold_inc_s", {s_tens, s_ones}, 8'h01);
    dec = 1'b1;
    repeat (20) tick();
    dec = 1'b0;
    repeat (4) tick();
    chk("hold_dec_a", {a_tens, a_ones}, 8'h00);
    chk("hold_dec_s", {s_tens, s_ones}, 8'h00);
    cur_a = 8'h00;
    cur_s = 8'h00;

    for (int i = 0; i < NROWS; i++) begin
      row_idx = i;
      apply_row(rows[i]);
    end
    row_idx = -1;

    // Reset mid-operation with a press already in flight and held across release.
    inc = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_a", {a_tens, a_ones}, 8'h00);
    chk("mid_rst_s", {s_tens, s_ones}, 8'h00);
    chk("mid_rst_r", {r_tens, r_ones}, 8'h25);
    chk("mid_rst_roll", 8'({a_roll, s_roll, r_roll}), 8'h00);
    repeat (6) tick();
    chk("held_after_rst_r", {r_tens, r_ones}, 8'h25);
    inc = 1'b0;
    repeat (4) tick();
    chk("rel_after_rst_r", {r_tens, r_ones}, 8'h25);
    inc = 1'b1;
    tick();
    tick();
    chk("repress_e1_r", {r_tens, r_ones}, 8'h25);
    tick();
    chk("repress_r", {r_tens, r_ones}, 8'h26);
    chk("repress_a", {a_tens, a_ones}, 8'h01);
    inc = 1'b0;
    repeat (4) tick();

    chk("a_roll_total", 8'(a_roll_cnt), 8'd5);
    chk("s_roll_total", 8'(s_roll_cnt), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
